// File: rtl/sha1_pkg.sv
// ----------------------------------------------------------------------------
// sha1_pkg
//   Shared SHA-1 definitions for the message-schedule and compression stages:
//   round count, window depth, round-index type, load-FSM encoding, the
//   rotate-left-by-one helper and the four round constants.
// ----------------------------------------------------------------------------
package sha1_pkg;

  localparam int SHA1_ROUNDS    = 80;
  localparam int SHA1_WIN_DEPTH = 16;
  localparam int SHA1_IDX_W     = 4;    // log2(SHA1_WIN_DEPTH)

  typedef logic [6:0] round_t;

  // Round constants, consumed by the compression stage.
  localparam logic [31:0] SHA1_K0 = 32'h5A82_7999;  // rounds  0..19
  localparam logic [31:0] SHA1_K1 = 32'h6ED9_EBA1;  // rounds 20..39
  localparam logic [31:0] SHA1_K2 = 32'h8F1B_BCDC;  // rounds 40..59
  localparam logic [31:0] SHA1_K3 = 32'hCA62_C1D6;  // rounds 60..79

  // Block-load FSM.
  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

endpackage

// File: rtl/sha1_w_regfile.sv
// ----------------------------------------------------------------------------
// sha1_w_regfile
//   Multi-read / single-write register file. Reads are asynchronous, the
//   single write lands on the rising clock edge. Contents are not reset.
//
// Ports
//   clk       clock
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_raddr   NUM_RD packed read addresses
//   o_rdata   NUM_RD packed read data (combinational)
// ----------------------------------------------------------------------------
module sha1_w_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int NUM_RD     = 4
) (
  input  logic                               clk,
  input  logic                               i_we,
  input  logic [ADDR_W-1:0]                  i_waddr,
  input  logic [DATA_WIDTH-1:0]              i_wdata,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]      i_raddr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign o_rdata[g] = r_mem[i_raddr[g]];
  end

endmodule

// File: rtl/sha1_w_schedule.sv
// ----------------------------------------------------------------------------
// sha1_w_schedule
//   SHA-1 message-schedule stage feeding the per-round compression stage.
//   Keeps a 16-word sliding window per channel. Blocks are loaded 16 words at
//   a time over a valid/ready stream; each round request returns W[t]
//   (stored word for t<16, otherwise rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]),
//   which is written back into the window slot t&15). Latency is 2 cycles.
//
// Build option
//   SHA1_W_ORDER_CHECK_EN : per-channel expected-round counters; an
//                           out-of-order request flags err, returns 0 and
//                           leaves the window untouched.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   i_msg_valid/o_msg_ready/i_msg_data/i_msg_channel
//                      block word stream, W0 first; channel taken on word 0
//   i_req_valid/i_req_channel/i_req_round
//                      round request (round 0..79)
//   o_w_valid/o_w_data/o_w_channel/o_w_round
//                      schedule word, 2 cycles after the request
//   o_ch_loaded        per-channel "window holds a live block"
//   o_err              sticky: unloaded channel, round > 79, or bad order
//
// DATA_WIDTH must be 32.
// ----------------------------------------------------------------------------
module sha1_w_schedule
  import sha1_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int CHANNEL_NUM_TOTAL = 64,
  parameter int CHANNEL_NUM_WIDTH = $clog2(CHANNEL_NUM_TOTAL)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_msg_valid,
  output logic                         o_msg_ready,
  input  logic [DATA_WIDTH-1:0]        i_msg_data,
  input  logic [CHANNEL_NUM_WIDTH-1:0] i_msg_channel,
  input  logic                         i_req_valid,
  input  logic [CHANNEL_NUM_WIDTH-1:0] i_req_channel,
  input  logic [6:0]                   i_req_round,
  output logic                         o_w_valid,
  output logic [DATA_WIDTH-1:0]        o_w_data,
  output logic [CHANNEL_NUM_WIDTH-1:0] o_w_channel,
  output logic [6:0]                   o_w_round,
  output logic [CHANNEL_NUM_TOTAL-1:0] o_ch_loaded,
  output logic                         o_err
);

  localparam int CW     = CHANNEL_NUM_WIDTH;
  localparam int AW     = CW + SHA1_IDX_W;
  localparam int DEPTH  = CHANNEL_NUM_TOTAL * SHA1_WIN_DEPTH;
  localparam int NUM_RD = 4;
  localparam int STAGES = 2;

  // --------------------------------------------------------------------------
  // Load FSM
  // --------------------------------------------------------------------------
  ld_state_e              r_state, w_state_nxt;
  logic [SHA1_IDX_W-1:0]  r_cnt;
  logic [CW-1:0]          r_ld_ch;
  logic                   r_ready_en;   // keeps msg_ready low the first cycle after reset
  logic                   w_msg_fire;
  logic                   w_ld_first;
  logic                   w_ld_last;
  logic [CW-1:0]          w_ld_ch;
  logic [SHA1_IDX_W-1:0]  w_ld_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LD_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      LD_IDLE: if (w_msg_fire)                 w_state_nxt = LD_LOAD;
      LD_LOAD: if (w_msg_fire && &r_cnt)       w_state_nxt = LD_IDLE;
      default:                                 w_state_nxt = LD_IDLE;
    endcase
  end

  // Requests own the write port: the stream is throttled whenever one is present.
  always_comb begin
    o_msg_ready = r_ready_en & ~i_req_valid;
    w_msg_fire  = i_msg_valid & o_msg_ready;
    w_ld_first  = 1'b0;
    w_ld_last   = 1'b0;
    w_ld_ch     = r_ld_ch;
    w_ld_idx    = r_cnt;
    unique case (r_state)
      LD_IDLE: begin
        w_ld_first = w_msg_fire;
        w_ld_ch    = i_msg_channel;
        w_ld_idx   = '0;
      end
      LD_LOAD: w_ld_last = w_msg_fire & (&r_cnt);
      default: ;
    endcase
  end

  // Word counter wraps 15->0 on the last word, which is the IDLE value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_ld_ch    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_msg_fire) begin
        r_cnt <= w_ld_idx + 1'b1;
        if (w_ld_first) r_ld_ch <= i_msg_channel;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request cycle 0: window reads, expansion, write-back
  // --------------------------------------------------------------------------
  logic [CHANNEL_NUM_TOTAL-1:0]          r_ch_loaded;
  logic [NUM_RD-1:0][AW-1:0]             w_raddr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]     w_rdata;
  logic [SHA1_IDX_W-1:0]                 w_t_lo;
  logic                                  w_in_range;
  logic                                  w_expand;
  logic                                  w_order_ok;
  logic                                  w_req_ok;
  logic                                  w_wb;
  logic [DATA_WIDTH-1:0]                 w_res;
  logic                                  w_we;
  logic [AW-1:0]                         w_waddr;
  logic [DATA_WIDTH-1:0]                 w_wdata;

  assign w_t_lo = i_req_round[SHA1_IDX_W-1:0];

  // Slot t&15 holds W[t-16] until this round overwrites it with W[t].
  assign w_raddr[0] = {i_req_channel, w_t_lo - 4'd3};
  assign w_raddr[1] = {i_req_channel, w_t_lo - 4'd8};
  assign w_raddr[2] = {i_req_channel, w_t_lo - 4'd14};
  assign w_raddr[3] = {i_req_channel, w_t_lo};

  assign w_in_range = i_req_round < 7'(SHA1_ROUNDS);
  assign w_expand   = i_req_round >= 7'(SHA1_WIN_DEPTH);

`ifdef SHA1_W_ORDER_CHECK_EN
  logic [6:0] r_exp_round [CHANNEL_NUM_TOTAL];

  assign w_order_ok = (i_req_round == r_exp_round[i_req_channel]);

  // Advances only on accepted requests, so a rejected out-of-order request
  // leaves the caller free to retry with the right round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNEL_NUM_TOTAL; c++) r_exp_round[c] <= '0;
    end else begin
      if (w_ld_last) r_exp_round[r_ld_ch] <= '0;
      if (w_req_ok)  r_exp_round[i_req_channel] <= r_exp_round[i_req_channel] + 7'd1;
    end
  end
`else
  assign w_order_ok = 1'b1;
`endif

  assign w_req_ok = i_req_valid & r_ch_loaded[i_req_channel] & w_in_range & w_order_ok;
  assign w_wb     = w_req_ok & w_expand;
  assign w_res    = w_expand ? rotl1(w_rdata[0] ^ w_rdata[1] ^ w_rdata[2] ^ w_rdata[3])
                             : w_rdata[3];

  // Load writes can only fire when no request is present, so the mux is
  // steered by i_req_valid alone.
  assign w_we    = w_wb | w_msg_fire;
  assign w_waddr = i_req_valid ? {i_req_channel, w_t_lo} : {w_ld_ch, w_ld_idx};
  assign w_wdata = i_req_valid ? w_res : i_msg_data;

  sha1_w_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW),
    .NUM_RD     (NUM_RD)
  ) u_win (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Loads and requests never act in the same cycle, so these updates are
  // mutually exclusive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch_loaded <= '0;
    end else begin
      if (w_ld_first) r_ch_loaded[i_msg_channel] <= 1'b0;
      if (w_ld_last)  r_ch_loaded[r_ld_ch]       <= 1'b1;
      if (w_req_ok && i_req_round == 7'(SHA1_ROUNDS - 1))
        r_ch_loaded[i_req_channel] <= 1'b0;
    end
  end

  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n)                       r_err <= 1'b0;
    else if (i_req_valid && !w_req_ok) r_err <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Stages 1..2
  // --------------------------------------------------------------------------
  logic [STAGES:1]         r_vld_pipe;
  logic [DATA_WIDTH-1:0]   r_s1_data;
  logic [CW-1:0]           r_s1_ch;
  round_t                  r_s1_round;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic [CW-1:0]           r_w_ch;
  round_t                  r_w_round;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_data  <= '0;
      r_s1_ch    <= '0;
      r_s1_round <= '0;
      r_w_data   <= '0;
      r_w_ch     <= '0;
      r_w_round  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_req_valid};
      if (i_req_valid) begin
        r_s1_data  <= w_req_ok ? w_res : '0;
        r_s1_ch    <= i_req_channel;
        r_s1_round <= i_req_round;
      end
      if (r_vld_pipe[1]) begin
        r_w_data  <= r_s1_data;
        r_w_ch    <= r_s1_ch;
        r_w_round <= r_s1_round;
      end
    end
  end

  assign o_w_valid   = r_vld_pipe[STAGES];
  assign o_w_data    = r_w_data;
  assign o_w_channel = r_w_ch;
  assign o_w_round   = r_w_round;
  assign o_ch_loaded = r_ch_loaded;
  assign o_err       = r_err;

endmodule
